// File: rtl/serial_rx.sv
// -----------------------------------------------------------------------------
// serial_rx
// UART receiver: 8 data bits LSB first, one start bit, NUM_STOP_BITS stop bits,
// no parity. Bit timing is derived from CLK_FREQ / BAUD_RATE. The start bit is
// re-checked at its centre and every later bit is sampled at its centre.
//
// Parameters
//   CLK_FREQ       system clock frequency in Hz
//   BAUD_RATE      line bit rate in bit/s (CLK_FREQ/BAUD_RATE must be >= 4)
//   NUM_STOP_BITS  stop bits expected per frame (1 or 2)
//
// Ports
//   clk          system clock, all logic on rising edge
//   rst          synchronous, active-high reset
//   en           receive enable, only looked at while idle
//   rx           asynchronous serial line, idle high
//   data_out     last correctly received byte
//   valid        one-cycle pulse, data_out updated in this cycle
//   busy         high while a frame is in progress
//   frame_error  one-cycle pulse, a stop bit was sampled low
// -----------------------------------------------------------------------------
module serial_rx #(
    parameter int CLK_FREQ      = 25_000_000,
    parameter int BAUD_RATE     = 115_200,
    parameter int NUM_STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       valid,
    output logic       busy,
    output logic       frame_error
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int HALF         = CLKS_PER_BIT / 2;
    localparam int CW           = $clog2(CLKS_PER_BIT);

    // Terminal counts for the half-bit start check and the full-bit sample.
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    // Value of the 1-bit stop counter at the final stop-bit sample.
    localparam logic          STOP_LAST = (NUM_STOP_BITS == 2) ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // Synchroniser stages; rx_sync_r is the only view of the line the FSM uses.
    logic         rx_meta_r;
    logic         rx_sync_r;

    // FSM state and datapath registers.
    state_t       state_r;
    logic [CW-1:0] cnt_r;
    logic [2:0]   bit_idx_r;
    logic         stop_cnt_r;
    logic [7:0]   shift_r;
    logic         err_r;
    logic [7:0]   data_r;
    logic         valid_r;
    logic         busy_r;
    logic         ferr_r;

    // Next-state values computed by the combinational process.
    state_t       state_s;
    logic [CW-1:0] cnt_s;
    logic [2:0]   bit_idx_s;
    logic         stop_cnt_s;
    logic [7:0]   shift_s;
    logic         err_s;
    logic [7:0]   data_s;
    logic         valid_s;
    logic         busy_s;
    logic         ferr_s;
    logic         bit_tick_s;

    // Two-flop synchroniser for the asynchronous line, idles high.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rx_sync_r <= rx_meta_r;
        end
    end

    // Next-state, datapath and output decode for the receive FSM.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        bit_idx_s  = bit_idx_r;
        stop_cnt_s = stop_cnt_r;
        shift_s    = shift_r;
        err_s      = err_r;
        data_s     = data_r;
        valid_s    = 1'b0;
        ferr_s     = 1'b0;
        bit_tick_s = (cnt_r == BIT_LAST);

        case (state_r)
            IDLE: begin
                if (en && !rx_sync_r) begin
                    cnt_s   = {CW{1'b0}};
                    state_s = START;
                end else begin
                    state_s = IDLE;
                end
            end

            START: begin
                if (cnt_r == HALF_LAST) begin
                    cnt_s = {CW{1'b0}};
                    if (!rx_sync_r) begin
                        // Start bit still low at its centre: a real frame.
                        bit_idx_s = 3'd0;
                        err_s     = 1'b0;
                        state_s   = DATA;
                    end else begin
                        // Line bounced back high: treat as a glitch.
                        state_s = IDLE;
                    end
                end else begin
                    cnt_s = cnt_r + CW'(1);
                end
            end

            DATA: begin
                if (bit_tick_s) begin
                    cnt_s   = {CW{1'b0}};
                    shift_s = {rx_sync_r, shift_r[7:1]};
                    if (bit_idx_r == 3'd7) begin
                        stop_cnt_s = 1'b0;
                        state_s    = STOP;
                    end else begin
                        bit_idx_s = bit_idx_r + 3'd1;
                    end
                end else begin
                    cnt_s = cnt_r + CW'(1);
                end
            end

            STOP: begin
                if (bit_tick_s) begin
                    cnt_s = {CW{1'b0}};
                    if (stop_cnt_r == STOP_LAST) begin
                        // Leave at mid-stop-bit so a back-to-back start edge,
                        // half a bit later, is still seen from IDLE.
                        state_s = IDLE;
                        err_s   = 1'b0;
                        if (err_r || !rx_sync_r) begin
                            ferr_s = 1'b1;
                        end else begin
                            valid_s = 1'b1;
                            data_s  = shift_r;
                        end
                    end else begin
                        stop_cnt_s = stop_cnt_r + 1'b1;
                        err_s      = err_r | ~rx_sync_r;
                    end
                end else begin
                    cnt_s = cnt_r + CW'(1);
                end
            end

            default: begin
                state_s = IDLE;
                cnt_s   = {CW{1'b0}};
            end
        endcase

        // busy is registered from the next state so it tracks state_r exactly.
        busy_s = (state_s != IDLE);
    end

    // State, datapath and registered output update.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            cnt_r      <= {CW{1'b0}};
            bit_idx_r  <= 3'd0;
            stop_cnt_r <= 1'b0;
            shift_r    <= 8'h00;
            err_r      <= 1'b0;
            data_r     <= 8'h00;
            valid_r    <= 1'b0;
            busy_r     <= 1'b0;
            ferr_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            bit_idx_r  <= bit_idx_s;
            stop_cnt_r <= stop_cnt_s;
            shift_r    <= shift_s;
            err_r      <= err_s;
            data_r     <= data_s;
            valid_r    <= valid_s;
            busy_r     <= busy_s;
            ferr_r     <= ferr_s;
        end
    end

    assign data_out    = data_r;
    assign valid       = valid_r;
    assign busy        = busy_r;
    assign frame_error = ferr_r;

endmodule

// File: tb/tb_serial_rx.sv
// -----------------------------------------------------------------------------
// tb_serial_rx
// Directed bench for serial_rx at 16 clocks per bit. dut1 expects one stop bit,
// dut2 expects two. A simple TX model drives each rx line bit by bit; a negedge
// monitor records valid / frame_error pulses and their cycle numbers.
// -----------------------------------------------------------------------------
module tb_serial_rx;

    localparam int CF  = 1_600_000;
    localparam int BR  = 100_000;
    localparam int CPB = 16;

    logic       clk;
    logic       rst;
    logic       en;
    logic       rx1;
    logic       rx2;
    logic [7:0] data1;
    logic [7:0] data2;
    logic       valid1;
    logic       valid2;
    logic       busy1;
    logic       busy2;
    logic       fe1;
    logic       fe2;

    int vec_cnt;
    int miscompare_cnt;
    int cyc;

    int         v_cnt    [2];
    int         fe_cnt   [2];
    int         busy_cyc [2];
    int         v_last   [2];
    int         v_prev   [2];
    logic [7:0] v_last_d [2];
    logic [7:0] v_prev_d [2];
    int         both_cnt;

    serial_rx #(.CLK_FREQ(CF), .BAUD_RATE(BR), .NUM_STOP_BITS(1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .rx(rx1),
        .data_out(data1), .valid(valid1), .busy(busy1), .frame_error(fe1)
    );

    serial_rx #(.CLK_FREQ(CF), .BAUD_RATE(BR), .NUM_STOP_BITS(2)) dut2 (
        .clk(clk), .rst(rst), .en(en), .rx(rx2),
        .data_out(data2), .valid(valid2), .busy(busy2), .frame_error(fe2)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Rising-edge counter used to time pulses relative to a start edge.
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor sampled away from the active edge.
    initial begin
        for (int i = 0; i < 2; i++) begin
            v_cnt[i] = 0; fe_cnt[i] = 0; busy_cyc[i] = 0;
            v_last[i] = 0; v_prev[i] = 0; v_last_d[i] = 8'h00; v_prev_d[i] = 8'h00;
        end
        both_cnt = 0;
    end
    always @(negedge clk) begin
        if (valid1) begin
            v_cnt[0]    <= v_cnt[0] + 1;
            v_prev[0]   <= v_last[0];
            v_prev_d[0] <= v_last_d[0];
            v_last[0]   <= cyc;
            v_last_d[0] <= data1;
        end
        if (valid2) begin
            v_cnt[1]    <= v_cnt[1] + 1;
            v_prev[1]   <= v_last[1];
            v_prev_d[1] <= v_last_d[1];
            v_last[1]   <= cyc;
            v_last_d[1] <= data2;
        end
        if (fe1) fe_cnt[0] <= fe_cnt[0] + 1;
        if (fe2) fe_cnt[1] <= fe_cnt[1] + 1;
        if (busy1) busy_cyc[0] <= busy_cyc[0] + 1;
        if (busy2) busy_cyc[1] <= busy_cyc[1] + 1;
        if ((valid1 && fe1) || (valid2 && fe2)) both_cnt <= both_cnt + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            miscompare_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges and land 1 time unit after the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input int which, input logic v);
        if (which == 0) rx1 = v;
        else            rx2 = v;
        tick(CPB);
    endtask

    task automatic send_frame(input int which, input logic [7:0] b,
                              input logic stop1, input logic stop2, input int nstop);
        drive_bit(which, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(which, b[i]);
        drive_bit(which, stop1);
        if (nstop == 2) drive_bit(which, stop2);
    endtask

    int vb, fb, bb, st, d;

    initial begin
        vec_cnt = 0;
        miscompare_cnt = 0;
        rx1 = 1'b1;
        rx2 = 1'b1;
        en  = 1'b0;
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(1);

        // Reset state.
        check_val("rst data1",  32'(data1),  32'h00);
        check_val("rst valid1", 32'(valid1), 32'h0);
        check_val("rst busy1",  32'(busy1),  32'h0);
        check_val("rst fe1",    32'(fe1),    32'h0);
        check_val("rst data2",  32'(data2),  32'h00);

        // Single byte 0xA5.
        en = 1'b1;
        tick(2);
        vb = v_cnt[0]; fb = fe_cnt[0]; st = cyc;
        fork
            send_frame(0, 8'hA5, 1'b1, 1'b1, 1);
            begin
                tick(4);
                check_val("a5 busy early", 32'(busy1), 32'h1);
                tick(146);
                check_val("a5 busy late", 32'(busy1), 32'h1);
            end
        join
        d = v_last[0] - st;
        check_val("a5 valid count", 32'(v_cnt[0] - vb), 32'd1);
        check_val($sformatf("a5 latency in 154..156 (saw %0d)", d), 32'(d >= 154 && d <= 156), 32'h1);
        check_val("a5 data at pulse", 32'(v_last_d[0]), 32'hA5);
        check_val("a5 data_out", 32'(data1), 32'hA5);
        check_val("a5 fe count", 32'(fe_cnt[0] - fb), 32'd0);
        check_val("a5 busy after", 32'(busy1), 32'h0);

        // Back-to-back 0x00 then 0xFF.
        tick(10);
        vb = v_cnt[0];
        send_frame(0, 8'h00, 1'b1, 1'b1, 1);
        send_frame(0, 8'hFF, 1'b1, 1'b1, 1);
        tick(4);
        check_val("b2b valid count", 32'(v_cnt[0] - vb), 32'd2);
        check_val("b2b spacing", 32'(v_last[0] - v_prev[0]), 32'd160);
        check_val("b2b first data", 32'(v_prev_d[0]), 32'h00);
        check_val("b2b second data", 32'(v_last_d[0]), 32'hFF);

        // Glitch: 4 clocks low.
        tick(10);
        vb = v_cnt[0]; fb = fe_cnt[0];
        rx1 = 1'b0;
        tick(4);
        rx1 = 1'b1;
        check_val("glitch busy seen", 32'(busy1), 32'h1);
        tick(8);
        check_val("glitch busy cleared", 32'(busy1), 32'h0);
        tick(10);
        check_val("glitch valid count", 32'(v_cnt[0] - vb), 32'd0);
        check_val("glitch fe count", 32'(fe_cnt[0] - fb), 32'd0);

        // Framing error after a good 0x3C.
        send_frame(0, 8'h3C, 1'b1, 1'b1, 1);
        tick(4);
        check_val("3c data_out", 32'(data1), 32'h3C);
        vb = v_cnt[0]; fb = fe_cnt[0];
        send_frame(0, 8'h5A, 1'b0, 1'b1, 1);
        rx1 = 1'b1;
        tick(30);
        check_val("ferr fe count", 32'(fe_cnt[0] - fb), 32'd1);
        check_val("ferr valid count", 32'(v_cnt[0] - vb), 32'd0);
        check_val("ferr data kept", 32'(data1), 32'h3C);

        // Two stop bits on dut2: bad second stop, then good frame.
        vb = v_cnt[1]; fb = fe_cnt[1];
        send_frame(1, 8'h81, 1'b1, 1'b0, 2);
        rx2 = 1'b1;
        tick(30);
        check_val("2stop fe count", 32'(fe_cnt[1] - fb), 32'd1);
        check_val("2stop no valid", 32'(v_cnt[1] - vb), 32'd0);
        check_val("2stop data kept", 32'(data2), 32'h00);
        fb = fe_cnt[1];
        st = cyc;
        send_frame(1, 8'h81, 1'b1, 1'b1, 2);
        tick(4);
        d = v_last[1] - st;
        check_val("2stop valid count", 32'(v_cnt[1] - vb), 32'd1);
        check_val("2stop data_out", 32'(data2), 32'h81);
        check_val($sformatf("2stop latency in 170..172 (saw %0d)", d), 32'(d >= 170 && d <= 172), 32'h1);
        check_val("2stop no new fe", 32'(fe_cnt[1] - fb), 32'd0);

        // en low: frame ignored.
        tick(10);
        en = 1'b0;
        vb = v_cnt[0]; fb = fe_cnt[0]; bb = busy_cyc[0];
        send_frame(0, 8'h55, 1'b1, 1'b1, 1);
        tick(4);
        check_val("en0 valid count", 32'(v_cnt[0] - vb), 32'd0);
        check_val("en0 fe count", 32'(fe_cnt[0] - fb), 32'd0);
        check_val("en0 busy cycles", 32'(busy_cyc[0] - bb), 32'd0);

        // Reset mid-byte. en is dropped with the reset so the tail of the
        // aborted frame is not taken for a new start edge.
        en = 1'b1;
        tick(4);
        vb = v_cnt[0]; fb = fe_cnt[0];
        fork
            send_frame(0, 8'h55, 1'b1, 1'b1, 1);
            begin
                tick(60);
                check_val("pre-rst busy", 32'(busy1), 32'h1);
                rst = 1'b1;
                en  = 1'b0;
                tick(2);
                rst = 1'b0;
                check_val("post-rst data", 32'(data1), 32'h00);
                check_val("post-rst busy", 32'(busy1), 32'h0);
                check_val("post-rst valid", 32'(valid1), 32'h0);
                check_val("post-rst fe", 32'(fe1), 32'h0);
            end
        join
        tick(4);
        check_val("rst valid count", 32'(v_cnt[0] - vb), 32'd0);
        check_val("rst fe count", 32'(fe_cnt[0] - fb), 32'd0);

        // Recovery: 0x55 received normally.
        en = 1'b1;
        tick(4);
        vb = v_cnt[0];
        st = cyc;
        send_frame(0, 8'h55, 1'b1, 1'b1, 1);
        tick(4);
        d = v_last[0] - st;
        check_val("55 valid count", 32'(v_cnt[0] - vb), 32'd1);
        check_val("55 data_out", 32'(data1), 32'h55);
        check_val($sformatf("55 latency in 154..156 (saw %0d)", d), 32'(d >= 154 && d <= 156), 32'h1);

        check_val("valid and fe never together", 32'(both_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompare_cnt);
        $finish;
    end

endmodule
